rx_slot_ctrl: RTL and testbench

Sequences the 2 KiB RX payload memory as a ring of fixed-size packet slots, replacing the free-running single-buffer address counter. It takes the UDP payload byte stream and frame-end/abort strobes, generates memory write address and strobe, and records per-slot lengths. It exposes the oldest committed slot to the CPU side and frees slots on a release pulse. It sits between rx_udp and the RX SRAM write port, in the RX_CLK domain.

---
 rtl/rx_slot_pkg.sv | 20 ++
 rtl/rx_slot_ring.sv | 69 ++++++
 rtl/rx_slot_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rx_slot_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_slot_pkg.sv
// rx_slot_pkg: shared types and default sizing for the RX slot ring.
//   rx_state_e    : frame-sequencing states of rx_slot_ctrl
//   RX_ADDR_W     : default RX memory byte address width
//   RX_SLOT_W     : default log2 of slot count
//   RX_SLOT_BYTES : bytes per slot for the default sizing
//   RX_LEN_W      : width of a slot length (holds 1..RX_SLOT_BYTES)
package rx_slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } rx_state_e;

  localparam int RX_ADDR_W     = 11;
  localparam int RX_SLOT_W     = 2;
  localparam int RX_SLOT_BYTES = 2 ** (RX_ADDR_W - RX_SLOT_W);
  localparam int RX_LEN_W      = RX_ADDR_W - RX_SLOT_W + 1;

endpackage

// File: rtl/rx_slot_ring.sv
// rx_slot_ring: write/read pointers, committed-slot count and per-slot
// length table for the RX slot ring.
//   RX_CLK, rst   : clock, synchronous active-high reset
//   commit        : close slot wp with length commit_len, advance wp
//   commit_len    : byte length of the slot being committed
//   release_req   : free the head slot (ignored when nothing is committed)
//   wp, rp        : slot being filled / oldest committed slot
//   slot_count    : number of committed slots
//   head_valid    : registered (slot_count != 0)
//   head_len      : registered length of the head slot
module rx_slot_ring
  import rx_slot_pkg::*;
#(
  parameter int SLOT_W = RX_SLOT_W,
  parameter int LEN_W  = RX_LEN_W
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              commit,
  input  logic [LEN_W-1:0]  commit_len,
  input  logic              release_req,
  output logic [SLOT_W-1:0] wp,
  output logic [SLOT_W-1:0] rp,
  output logic [SLOT_W:0]   slot_count,
  output logic              head_valid,
  output logic [LEN_W-1:0]  head_len
);

  localparam int SLOTS = 2 ** SLOT_W;

  logic [LEN_W-1:0]  len_q [SLOTS];
  logic              rel_ok;
  logic [SLOT_W-1:0] rp_nxt;
  logic [SLOT_W:0]   count_nxt;

  always_comb begin
    rel_ok    = release_req && (slot_count != '0);
    rp_nxt    = rp + SLOT_W'(rel_ok);
    count_nxt = slot_count;
    if (commit && !rel_ok)
      count_nxt = slot_count + (SLOT_W+1)'(1);
    else if (!commit && rel_ok)
      count_nxt = slot_count - (SLOT_W+1)'(1);
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      slot_count <= '0;
      head_valid <= 1'b0;
      head_len   <= '0;
      for (int i = 0; i < SLOTS; i++)
        len_q[i] <= '0;
    end else begin
      if (commit) begin
        len_q[wp] <= commit_len;
        wp        <= wp + SLOT_W'(1);
      end
      rp         <= rp_nxt;
      slot_count <= count_nxt;
      head_valid <= (count_nxt != '0);
      // The table write lands this edge, so a commit that becomes the new
      // head must bypass the table.
      head_len   <= (commit && (wp == rp_nxt)) ? commit_len : len_q[rp_nxt];
    end
  end

endmodule

// File: rtl/rx_slot_ctrl.sv
// rx_slot_ctrl: sequences the RX payload memory as a ring of fixed-size
// packet slots. Payload bytes are written one cycle after they arrive;
// good frames are committed to the ring, bad/oversize/no-room frames are
// counted as drops.
//   RX_CLK, rst          : clock, synchronous active-high reset
//   pld_v, pld_data      : payload byte stream
//   pld_done, pld_abort  : frame end strobes (commit / discard)
//   mem_web, mem_addr, mem_din : SRAM write port (web active-low)
//   sw_release           : CPU is done with the head slot
//   head_valid, head_slot, head_len, slot_count : head-of-ring status
//   rx_irq               : level interrupt, equals head_valid
//   drop_cnt             : saturating dropped-frame counter
//
// state    | meaning
// ST_IDLE  | between frames, waiting for the first byte
// ST_WRITE | frame in progress, bytes go to slot wp at offset
// ST_DROP  | frame being discarded (ring full or slot overflow)
module rx_slot_ctrl
  import rx_slot_pkg::*;
#(
  parameter int ADDR_W = RX_ADDR_W,
  parameter int SLOT_W = RX_SLOT_W,
  parameter int CNT_W  = 16
) (
  input  logic                     RX_CLK,
  input  logic                     rst,
  input  logic                     pld_v,
  input  logic [7:0]               pld_data,
  input  logic                     pld_done,
  input  logic                     pld_abort,
  output logic                     mem_web,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_din,
  input  logic                     sw_release,
  output logic                     head_valid,
  output logic [SLOT_W-1:0]        head_slot,
  output logic [ADDR_W-SLOT_W:0]   head_len,
  output logic [SLOT_W:0]          slot_count,
  output logic                     rx_irq,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int LEN_W = ADDR_W - SLOT_W + 1;
  localparam int SLOTS = 2 ** SLOT_W;
  localparam logic [LEN_W-1:0] SLOT_END = LEN_W'(2 ** (ADDR_W - SLOT_W));

  rx_state_e         state, state_nxt;
  logic [LEN_W-1:0]  offset, offset_nxt;
  logic              web_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        din_nxt;
  logic              commit;
  logic [LEN_W-1:0]  commit_len;
  logic              drop_inc;
  logic              ring_full;
  logic [SLOT_W-1:0] wp;
  logic [ADDR_W-1:0] byte_addr;

  assign ring_full = (slot_count == (SLOT_W+1)'(SLOTS));
  assign byte_addr = {wp, offset[LEN_W-2:0]};

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    web_nxt    = 1'b1;
    addr_nxt   = mem_addr;
    din_nxt    = mem_din;
    commit     = 1'b0;
    commit_len = offset;
    drop_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pld_v) begin
          if (ring_full) begin
            state_nxt = ST_DROP;
          end else begin
            web_nxt    = 1'b0;
            addr_nxt   = {wp, {(LEN_W-1){1'b0}}};
            din_nxt    = pld_data;
            offset_nxt = LEN_W'(1);
            state_nxt  = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (pld_abort) begin
          drop_inc   = 1'b1;
          offset_nxt = '0;
          state_nxt  = ST_IDLE;
        end else if (pld_v && (offset == SLOT_END)) begin
          // Byte past the end of the slot: the whole frame is lost. If the
          // frame also ends here there is no DROP cycle to count it in.
          offset_nxt = '0;
          if (pld_done) begin
            drop_inc  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DROP;
          end
        end else if (pld_done) begin
          if (pld_v) begin
            web_nxt    = 1'b0;
            addr_nxt   = byte_addr;
            din_nxt    = pld_data;
            commit_len = offset + LEN_W'(1);
          end
          commit     = pld_v || (offset != '0);
          offset_nxt = '0;
          state_nxt  = ST_IDLE;
        end else if (pld_v) begin
          web_nxt    = 1'b0;
          addr_nxt   = byte_addr;
          din_nxt    = pld_data;
          offset_nxt = offset + LEN_W'(1);
        end
      end
      ST_DROP: begin
        if (pld_done || pld_abort) begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        offset_nxt = '0;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state    <= ST_IDLE;
      offset   <= '0;
      mem_web  <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      offset   <= offset_nxt;
      mem_web  <= web_nxt;
      mem_addr <= addr_nxt;
      mem_din  <= din_nxt;
      if (drop_inc && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  rx_slot_ring #(
    .SLOT_W (SLOT_W),
    .LEN_W  (LEN_W)
  ) u_ring (
    .RX_CLK      (RX_CLK),
    .rst         (rst),
    .commit      (commit),
    .commit_len  (commit_len),
    .release_req (sw_release),
    .wp          (wp),
    .rp          (head_slot),
    .slot_count  (slot_count),
    .head_valid  (head_valid),
    .head_len    (head_len)
  );

  assign rx_irq = head_valid;

endmodule

// File: tb/tb_rx_slot_ctrl.sv
// Bench for rx_slot_ctrl: directed scenarios with literal expectations plus
// randomized frames, all checked every cycle against a queue-based model.
module tb_rx_slot_ctrl;

  localparam int ADDR_W = 11;
  localparam int SLOT_W = 2;
  localparam int CNT_W  = 16;
  localparam int SLOT_B = 512;

  logic              RX_CLK = 1'b0;
  logic              rst = 1'b1;
  logic              pld_v = 1'b0;
  logic [7:0]        pld_data = '0;
  logic              pld_done = 1'b0;
  logic              pld_abort = 1'b0;
  logic              sw_release = 1'b0;
  logic              mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              head_valid;
  logic [SLOT_W-1:0] head_slot;
  logic [ADDR_W-SLOT_W:0] head_len;
  logic [SLOT_W:0]   slot_count;
  logic              rx_irq;
  logic [CNT_W-1:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 RX_CLK = ~RX_CLK;

  rx_slot_ctrl #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .pld_v(pld_v), .pld_data(pld_data),
    .pld_done(pld_done), .pld_abort(pld_abort), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_din(mem_din), .sw_release(sw_release),
    .head_valid(head_valid), .head_slot(head_slot), .head_len(head_len),
    .slot_count(slot_count), .rx_irq(rx_irq), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Committed frames are a queue of lengths; a frame in progress is just a
  // byte count plus "receiving"/"discarding" flags.
  int q_len[$];
  int m_wslot, m_rp, m_nbytes, m_drops, m_addr, m_din;
  bit m_recv, m_discard, m_web;
  bit m_rel_ok;

  task automatic m_reset();
    q_len.delete();
    m_wslot = 0; m_rp = 0; m_nbytes = 0; m_drops = 0;
    m_addr = 0; m_din = 0; m_recv = 0; m_discard = 0; m_web = 1;
  endtask

  task automatic m_write(input int a, input int d);
    m_web = 0; m_addr = a; m_din = d;
  endtask

  initial m_reset();

  always @(posedge RX_CLK) begin
    if (rst) begin
      m_reset();
    end else begin
      m_web = 1;
      m_rel_ok = sw_release && (q_len.size() > 0);
      if (m_discard) begin
        if (pld_done || pld_abort) begin m_drops++; m_discard = 0; end
      end else if (!m_recv) begin
        if (pld_v) begin
          if (q_len.size() == 4) m_discard = 1;
          else begin m_write(m_wslot * SLOT_B, pld_data); m_nbytes = 1; m_recv = 1; end
        end
      end else begin
        if (pld_abort) begin
          m_drops++; m_recv = 0;
        end else if (pld_v && m_nbytes == SLOT_B) begin
          m_recv = 0;
          if (pld_done) m_drops++;
          else m_discard = 1;
        end else if (pld_done) begin
          if (pld_v) begin m_write(m_wslot * SLOT_B + m_nbytes, pld_data); m_nbytes++; end
          q_len.push_back(m_nbytes);
          m_wslot = (m_wslot + 1) % 4;
          m_recv = 0;
        end else if (pld_v) begin
          m_write(m_wslot * SLOT_B + m_nbytes, pld_data); m_nbytes++;
        end
      end
      if (m_rel_ok) begin
        void'(q_len.pop_front());
        m_rp = (m_rp + 1) % 4;
      end
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  int wr_cnt = 0;
  int last_wr_addr = -1;
  int last_wr_din = -1;

  always @(negedge RX_CLK) begin
    if (mem_web === 1'b0) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_din = mem_din;
    end
    if (chk_en) begin
      check("mem_web", mem_web, m_web);
      if (!m_web) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_din", mem_din, m_din);
      end
      check("head_valid", head_valid, q_len.size() != 0);
      check("rx_irq", rx_irq, q_len.size() != 0);
      check("slot_count", slot_count, q_len.size());
      check("head_slot", head_slot, m_rp);
      if (q_len.size() != 0) check("head_len", head_len, q_len[0]);
      check("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit v, input logic [7:0] d, input bit dn, input bit ab,
                      input bit rl, input bit r);
    pld_v = v; pld_data = d; pld_done = dn; pld_abort = ab; sw_release = rl; rst = r;
    @(posedge RX_CLK);
    #1;
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  // endk: 0 done after last byte, 1 abort, 2 done with last byte,
  //       3 no end, 4 reset instead of end
  task automatic send_frame(input int n, input int endk, input int gap_p,
                            input int rel_p, input bit rnd_data);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      while (pct(gap_p)) step(0, 8'h00, 0, 0, pct(rel_p), 0);
      d = rnd_data ? 8'($urandom) : 8'(i);
      step(1, d, (endk == 2) && (i == n - 1), 0, pct(rel_p), 0);
    end
    case (endk)
      0: step(0, 8'h00, 1, 0, pct(rel_p), 0);
      1: step(0, 8'h00, 0, 1, pct(rel_p), 0);
      4: step(1, 8'hA5, 0, 0, 0, 1);
      default: ;
    endcase
    step(0, 8'h00, 0, 0, pct(rel_p), 0);
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 0);
  endtask

  int w0;
  int len, endk, relp;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("rst_mem_web", mem_web, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_head_valid", head_valid, 0);
    check("rst_head_len", head_len, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // single 10-byte frame
    w0 = wr_cnt;
    send_frame(10, 0, 0, 0, 0);
    check("t1_writes", wr_cnt - w0, 10);
    check("t1_last_addr", last_wr_addr, 9);
    check("t1_last_din", last_wr_din, 9);
    check("t1_head_valid", head_valid, 1);
    check("t1_head_slot", head_slot, 0);
    check("t1_head_len", head_len, 10);
    check("t1_rx_irq", rx_irq, 1);
    step(0, 8'h00, 0, 0, 1, 0);
    check("t1_rel_count", slot_count, 0);
    check("t1_rel_irq", rx_irq, 0);

    // five 64-byte frames, no release
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_frame(64, 0, 0, 0, 0);
      check("t2_last_addr", last_wr_addr, k * 512 + 63);
    end
    check("t2_count", slot_count, 4);
    w0 = wr_cnt;
    send_frame(64, 0, 0, 0, 0);
    check("t2_no_write", wr_cnt - w0, 0);
    check("t2_drop", drop_cnt, 1);
    check("t2_count_full", slot_count, 4);

    // 600-byte frame overflows slot 0
    do_reset();
    w0 = wr_cnt;
    send_frame(600, 0, 0, 0, 0);
    check("t3_writes", wr_cnt - w0, 512);
    check("t3_last_addr", last_wr_addr, 511);
    check("t3_count", slot_count, 0);
    check("t3_drop", drop_cnt, 1);
    send_frame(4, 0, 0, 0, 0);
    check("t3_next_slot", head_slot, 0);
    check("t3_next_len", head_len, 4);
    check("t3_next_addr", last_wr_addr, 3);

    // abort after 20 bytes, then 8-byte frame
    do_reset();
    send_frame(20, 1, 0, 0, 0);
    send_frame(8, 0, 0, 0, 0);
    check("t4_last_addr", last_wr_addr, 7);
    check("t4_head_len", head_len, 8);
    check("t4_head_slot", head_slot, 0);
    check("t4_drop", drop_cnt, 1);

    // reset mid-frame after 30 bytes (no write in the reset cycle)
    w0 = wr_cnt;
    send_frame(30, 4, 0, 0, 0);
    check("t6_writes", wr_cnt - w0, 30);
    check("t6_web", mem_web, 1);
    check("t6_addr", mem_addr, 0);
    check("t6_count", slot_count, 0);
    check("t6_irq", rx_irq, 0);
    check("t6_drop", drop_cnt, 0);
    send_frame(4, 0, 0, 0, 0);
    check("t6_slot", head_slot, 0);
    check("t6_len", head_len, 4);

    // done with last byte, then commit and release in the same cycle
    do_reset();
    send_frame(5, 2, 0, 0, 0);
    check("t5_len_with_byte", head_len, 5);
    send_frame(6, 0, 0, 0, 0);
    check("t5_count2", slot_count, 2);
    for (int i = 0; i < 7; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0);
    check("t5_same_count", slot_count, 2);
    check("t5_same_slot", head_slot, 1);
    check("t5_same_len", head_len, 6);

    // randomized traffic
    for (int f = 0; f < 70; f++) begin
      case ($urandom_range(9))
        0:       len = $urandom_range(560, 500);
        1, 2:    len = $urandom_range(511, 81);
        default: len = $urandom_range(80, 1);
      endcase
      endk = $urandom_range(24);
      if (endk < 14) endk = 0;
      else if (endk < 19) endk = 2;
      else if (endk < 23) endk = 1;
      else if (endk < 24) endk = 3;
      else endk = 4;
      relp = ($urandom_range(2) == 0) ? 0 : 4;
      send_frame(len, endk, 20, relp, 1);
      for (int i = 0; i < $urandom_range(4); i++) step(0, 8'h00, 0, 0, pct(30), 0);
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0, 1, 0);
    check("final_drained", slot_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
